// File: rtl/tone_pkg.sv
// Shared constants for the tone sequencer: pitch table, state encoding, duty codes.
// The GAP state encoding exists only when TONE_SEQ_GAP_EN is defined.
package tone_pkg;

    localparam int NUM_TONES = 17;

    // Chromatic C4..E5, rounded to whole Hz
    localparam int FREQ_HZ [NUM_TONES] = '{
        262, 277, 294, 311, 330, 349, 370, 392, 415,
        440, 466, 494, 523, 554, 587, 622, 659
    };

    localparam logic [4:0] REST = 5'd31;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
`ifdef TONE_SEQ_GAP_EN
    localparam logic [1:0] S_GAP   = 2'd3;
`endif

    localparam logic [6:0] DUTY_HI  = 7'd75;
    localparam logic [6:0] DUTY_LO  = 7'd25;
    localparam logic [6:0] DUTY_OFF = 7'd0;

    // Pitch indices past the table reuse its top entry.
    function automatic logic [31:0] half_period(input int sys_hz, input int idx);
        int i;
        i = (idx >= NUM_TONES) ? NUM_TONES - 1 : idx;
        return 32'(sys_hz / (2 * FREQ_HZ[i]));
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter and tone flip-flop. load clears phase and tone and latches a new
// limit; run counts and toggles at the limit; with neither asserted the tone is held at 0.
module tone_divider #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tone_o,
    output logic             tone_d_o
);

    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             tone_q, tone_d;

    always_comb begin
        limit_d = limit_q;
        phase_d = '0;
        tone_d  = 1'b0;
        if (load_i) begin
            limit_d = limit_i;
        end else if (run_i) begin
            if (phase_q == limit_q) begin
                tone_d = ~tone_q;
            end else begin
                phase_d = phase_q + 1'b1;
                tone_d  = tone_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            limit_q <= '0;
            tone_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            limit_q <= limit_d;
            tone_q  <= tone_d;
        end
    end

    assign tone_o   = tone_q;
    assign tone_d_o = tone_d;

endmodule

// File: rtl/tone_sequencer.sv
// Programmable melody player: song RAM, IDLE/FETCH/PLAY sequencing, tone and duty outputs.
// Define TONE_SEQ_GAP_EN to insert a silent GAP of GAP_TICKS cycles (>= 1) after every note.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int SYS_FREQ_HZ = 100_000_000,
    parameter int BEAT_TICKS  = 75_000_000,
    parameter int NOTE_W      = 5,
    parameter int ADDR_W      = 6,
    parameter int DUR_W       = 2
`ifdef TONE_SEQ_GAP_EN
    ,
    parameter int GAP_TICKS   = 5_000_000
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en_i,
    input  logic [ADDR_W-1:0]         wr_addr_i,
    input  logic [DUR_W+NOTE_W-1:0]   wr_data_i,
    input  logic [ADDR_W-1:0]         song_len_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      loop_i,
    output logic                      tone_o,
    output logic [6:0]                duty_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [ADDR_W-1:0]         note_addr_o,
    output logic [1:0]                state_o
);

    localparam int                ENTRY_W = DUR_W + NOTE_W;
    localparam int                NUM_P   = 1 << NOTE_W;
    localparam logic [NOTE_W-1:0] REST_P  = {NOTE_W{1'b1}};

    logic [ENTRY_W-1:0] ram_q [1 << ADDR_W];
    logic [ENTRY_W-1:0] rd_q;
    logic [NOTE_W-1:0]  rd_pitch;
    logic [DUR_W-1:0]   rd_dur;
    logic [31:0]        hp_rom [NUM_P];

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  note_addr_q, note_addr_d;
    logic [63:0]        dur_q, dur_d;
    logic               rest_q, rest_d;
    logic [6:0]         duty_q, duty_d;
    logic               busy_q, done_q, done_d;
    logic [1:0]         adv_state;
    logic [ADDR_W-1:0]  adv_addr;
    logic               adv_done;
    logic               div_load, div_run, tone_d;

    // Read address is the next-state address so the entry is ready during FETCH.
    always_ff @(posedge clk) begin
        if (wr_en_i) ram_q[wr_addr_i] <= wr_data_i;
        rd_q <= ram_q[note_addr_d];
    end

    assign rd_pitch = rd_q[NOTE_W-1:0];
    assign rd_dur   = rd_q[ENTRY_W-1:NOTE_W];

    for (genvar g = 0; g < NUM_P; g++) begin : g_hp
        assign hp_rom[g] = half_period(SYS_FREQ_HZ, g) - 32'd1;
    end

    always_comb begin
        adv_done = 1'b0;
        if (note_addr_q < song_len_i) begin
            adv_state = S_FETCH;
            adv_addr  = note_addr_q + 1'b1;
        end else if (loop_i) begin
            adv_state = S_FETCH;
            adv_addr  = '0;
        end else begin
            adv_state = S_IDLE;
            adv_addr  = note_addr_q;
            adv_done  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        note_addr_d = note_addr_q;
        dur_d       = dur_q;
        rest_d      = rest_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d     = S_FETCH;
                note_addr_d = '0;
            end
            S_FETCH: begin
                state_d = S_PLAY;
                dur_d   = (64'(BEAT_TICKS) << rd_dur) - 64'd1;
                rest_d  = (rd_pitch == REST_P);
            end
            S_PLAY: if (dur_q == 64'd0) begin
`ifdef TONE_SEQ_GAP_EN
                state_d = S_GAP;
                dur_d   = 64'(GAP_TICKS - 1);
`else
                state_d     = adv_state;
                note_addr_d = adv_addr;
                done_d      = adv_done;
`endif
            end else begin
                dur_d = dur_q - 64'd1;
            end
`ifdef TONE_SEQ_GAP_EN
            S_GAP: if (dur_q == 64'd0) begin
                state_d     = adv_state;
                note_addr_d = adv_addr;
                done_d      = adv_done;
            end else begin
                dur_d = dur_q - 64'd1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (stop_i) begin
            state_d     = S_IDLE;
            note_addr_d = note_addr_q;
            done_d      = 1'b0;
        end
    end

    // Divider controls look at the next state so the tone is already 0 in FETCH/GAP/IDLE.
    assign div_load = (state_q == S_FETCH) && (state_d == S_PLAY);
    assign div_run  = (state_q == S_PLAY) && (state_d == S_PLAY) && !rest_q;

    tone_divider #(.CNT_W(32)) u_div (
        .clk      (clk),
        .reset    (reset),
        .load_i   (div_load),
        .run_i    (div_run),
        .limit_i  (hp_rom[rd_pitch]),
        .tone_o   (tone_o),
        .tone_d_o (tone_d)
    );

    assign duty_d = (state_d == S_PLAY && !rest_d) ? (tone_d ? DUTY_HI : DUTY_LO) : DUTY_OFF;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            note_addr_q <= '0;
            dur_q       <= '0;
            rest_q      <= 1'b0;
            duty_q      <= DUTY_OFF;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_addr_q <= note_addr_d;
            dur_q       <= dur_d;
            rest_q      <= rest_d;
            duty_q      <= duty_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= done_d;
        end
    end

    assign duty_o      = duty_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign note_addr_o = note_addr_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: single-note vector table plus multi-note, loop, stop and reset sequences.
module tb_tone_sequencer;
    import tone_pkg::*;

    localparam int AW = 6;
    localparam int NW = 5;
    localparam int DW = 2;
`ifdef TONE_SEQ_GAP_EN
    localparam int G = 50;
`else
    localparam int G = 0;
`endif

    logic          clk, reset, wr_en, start, stop, loop_r;
    logic [AW-1:0] wr_addr, song_len, note_addr;
    logic [DW+NW-1:0] wr_data;
    logic          tone, busy, done;
    logic [6:0]    duty;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    int m_rise, m_high, m_done_n, m_done_cnt, m_silent, m_bad;
    int m_a1, m_a2, m_wrap, m_noisy1, m_idle;

    tone_sequencer #(
        .SYS_FREQ_HZ(100_000),
        .BEAT_TICKS (1000),
        .NOTE_W     (NW),
        .ADDR_W     (AW),
        .DUR_W      (DW)
`ifdef TONE_SEQ_GAP_EN
        ,
        .GAP_TICKS  (G)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .song_len_i (song_len),
        .start_i    (start),
        .stop_i     (stop),
        .loop_i     (loop_r),
        .tone_o     (tone),
        .duty_o     (duty),
        .busy_o     (busy),
        .done_o     (done),
        .note_addr_o(note_addr),
        .state_o    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int v);
        exp_q.push_back(32'(v));
    endtask

    task automatic pop_check(input string name, input int act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=%0d expected=<empty queue>", name, act);
        end else begin
            check(name, act, int'(exp_q.pop_front()));
        end
    endtask

    task automatic wr(input int a, input int d, input int p);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = {DW'(d), NW'(p)};
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Pulses start, then samples one output set per cycle until busy drops or max_n cycles.
    task automatic play(input int again_n, input int stop_n, input int max_n);
        int  n;
        bit  hi_done;
        n = 0;
        hi_done = 1'b0;
        m_rise = 0; m_high = 0; m_done_n = 0; m_done_cnt = 0; m_silent = 0; m_bad = 0;
        m_a1 = 0; m_a2 = 0; m_wrap = 0; m_noisy1 = 0; m_idle = 0;
        start = 1'b1;
        while (n < max_n) begin
            @(negedge clk);
            n++;
            if (tone && m_rise == 0) m_rise = n;
            if (m_rise != 0 && !hi_done) begin
                if (tone) m_high++;
                else hi_done = 1'b1;
            end
            if (done) begin
                m_done_cnt++;
                if (m_done_n == 0) m_done_n = n;
            end
            if (busy && !tone && duty == 7'd0) m_silent++;
            if (busy) begin
                if (tone && duty != 7'd75) m_bad++;
                if (!tone && duty != 7'd25 && duty != 7'd0) m_bad++;
            end else if (tone || duty != 7'd0) begin
                m_bad++;
            end
            if (note_addr == 1 && m_a1 == 0) m_a1 = n;
            if (note_addr == 2 && m_a2 == 0) m_a2 = n;
            if (note_addr == 0 && m_a2 != 0 && m_wrap == 0) m_wrap = n;
            if (note_addr == 1 && (tone || duty != 7'd0)) m_noisy1++;
            start = (n == again_n);
            stop  = (n == stop_n);
            if (!busy) begin
                m_idle = n;
                break;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    typedef struct {
        int pitch;
        int dur;
        int exp_rise;
        int exp_high;
        int exp_done;
        int exp_silent;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0,  0, 192, 190, 1002 + G, 1 + G};
        vecs[1] = '{1,  1, 182, 180, 2002 + G, 1 + G};
        vecs[2] = '{2,  0, 172, 170, 1002 + G, 1 + G};
        vecs[3] = '{9,  2, 115, 113, 4002 + G, 1 + G};
        vecs[4] = '{16, 0,  77,  75, 1002 + G, 1 + G};
        vecs[5] = '{31, 0,   0,   0, 1002 + G, 1001 + G};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        song_len = '0; start = 1'b0; stop = 1'b0; loop_r = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tone", int'(tone), 0);
        check("rst_duty", int'(duty), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(note_addr), 0);
        check("rst_state", int'(dbg_state), int'(S_IDLE));

        // Single-note table: one entry, song_len 0, no loop
        for (int i = 0; i < 6; i++) begin
            wr(0, vecs[i].dur, vecs[i].pitch);
            song_len = '0;
            loop_r   = 1'b0;
            push(vecs[i].exp_rise);
            push(vecs[i].exp_high);
            push(vecs[i].exp_done);
            push(1);
            push(vecs[i].exp_silent);
            push(0);
            play(0, 0, 6000);
            pop_check($sformatf("v%0d_rise", i), m_rise);
            pop_check($sformatf("v%0d_high", i), m_high);
            pop_check($sformatf("v%0d_done_n", i), m_done_n);
            pop_check($sformatf("v%0d_done_cnt", i), m_done_cnt);
            pop_check($sformatf("v%0d_silent", i), m_silent);
            pop_check($sformatf("v%0d_duty_bad", i), m_bad);
        end

        // Three notes, rest in the middle, no loop
        wr(0, 0, 0);
        wr(1, 1, 31);
        wr(2, 2, 4);
        song_len = AW'(2);
        loop_r   = 1'b0;
        push(1002 + G); push(3003 + 2 * G); push(7004 + 3 * G); push(1); push(0); push(0); push(192);
        play(0, 0, 9000);
        pop_check("s3_addr1_n", m_a1);
        pop_check("s3_addr2_n", m_a2);
        pop_check("s3_done_n", m_done_n);
        pop_check("s3_done_cnt", m_done_cnt);
        pop_check("s3_rest_noise", m_noisy1);
        pop_check("s3_duty_bad", m_bad);
        pop_check("s3_rise", m_rise);

        // Same song looping, then stop
        loop_r = 1'b1;
        push(7004 + 3 * G); push(0); push(7105 + 3 * G); push(0);
        play(0, 7104 + 3 * G, 9000);
        pop_check("loop_wrap_n", m_wrap);
        pop_check("loop_done_cnt", m_done_cnt);
        pop_check("loop_stop_idle_n", m_idle);
        pop_check("loop_duty_bad", m_bad);
        loop_r = 1'b0;
        repeat (5) @(negedge clk);
        check("stop_no_done", int'(done), 0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", int'(busy), 0);
        check("startstop_state", int'(dbg_state), int'(S_IDLE));
        @(negedge clk);
        check("startstop_busy2", int'(busy), 0);

        // start re-asserted while busy must be ignored
        push(1002 + G); push(7004 + 3 * G); push(1); push(192);
        play(500, 0, 9000);
        pop_check("rebusy_addr1_n", m_a1);
        pop_check("rebusy_done_n", m_done_n);
        pop_check("rebusy_done_cnt", m_done_cnt);
        pop_check("rebusy_rise", m_rise);

        // Two audible notes: one silent FETCH between them (plus gaps)
        wr(1, 0, 2);
        song_len = AW'(1);
        push(2 + 2 * G); push(2003 + 2 * G); push(1002 + G);
        play(0, 0, 4000);
        pop_check("two_silent", m_silent);
        pop_check("two_done_n", m_done_n);
        pop_check("two_addr1_n", m_a1);

        // Reset in the middle of the third note; RAM must survive
        wr(1, 1, 31);
        song_len = AW'(2);
        play(0, 0, 3500);
        check("pre_rst_addr", int'(note_addr), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_tone", int'(tone), 0);
        check("mid_rst_duty", int'(duty), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_addr", int'(note_addr), 0);
        check("mid_rst_state", int'(dbg_state), int'(S_IDLE));
        @(negedge clk);
        push(1002 + G); push(3003 + 2 * G); push(7004 + 3 * G); push(0);
        play(0, 0, 9000);
        pop_check("ram_kept_addr1_n", m_a1);
        pop_check("ram_kept_addr2_n", m_a2);
        pop_check("ram_kept_done_n", m_done_n);
        pop_check("ram_kept_rest_noise", m_noisy1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
